// File: rtl/secure_serdes_burst_encryptor_pkg.sv
// Shared constants for the burst encryptor: FSM state encoding and key-slice helpers.
package secure_serdes_burst_encryptor_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_XOR   = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    function automatic int key_slices(input int key_w, input int word_w);
        return key_w / word_w;
    endfunction

    // Index width for the rotating key slice; never narrower than one bit.
    function automatic int key_idx_w(input int key_w, input int word_w);
        return (key_w / word_w > 1) ? $clog2(key_w / word_w) : 1;
    endfunction

endpackage

// File: rtl/serdes_shift_word.sv
// WORD_W-bit shift register, MSB first, with parallel load.
// Serves as SIPO for the A/B inputs and as PISO for the ciphertext.
module serdes_shift_word #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_val,
    input  logic              shift_en,
    input  logic              shift_in,
    output logic [WORD_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= {q[WORD_W-2:0], shift_in};
        end
    end

endmodule

// File: rtl/secure_serdes_burst_encryptor.sv
// Burst serial encryptor: shifts in A/B words, XORs with rotating key slices,
// and shifts the ciphertext out MSB first.
//
//  state | meaning
//  IDLE  | waiting for start; len==0 bursts complete here
//  SHIFT | sampling a_bit/b_bit for WORD_W cycles
//  XOR   | combine A, B and key slice; first output bit registered
//  OUT   | emitting remaining ciphertext bits, then next word or done
module secure_serdes_burst_encryptor
    import secure_serdes_burst_encryptor_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int KEY_W  = 128,
    parameter int LEN_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [LEN_W-1:0] burst_len,
    input  logic [KEY_W-1:0] key,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             in_ready,
    output logic             cipher_out,
    output logic             cipher_valid,
    output logic             done,
    output logic             busy
);

    localparam int KEY_SLICES = key_slices(KEY_W, WORD_W);
    localparam int IDX_W      = key_idx_w(KEY_W, WORD_W);
    localparam int CNT_W      = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_SLICES - 1);

    if ((KEY_W % WORD_W) != 0 || WORD_W < 2) begin : g_param_check
        $error("secure_serdes_burst_encryptor: KEY_W must be a multiple of WORD_W and WORD_W >= 2");
    end

    logic [1:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [IDX_W-1:0]  word_idx;
    logic [LEN_W-1:0]  words_left;
    logic [KEY_W-1:0]  key_r;
    logic              mode_r;
    logic [WORD_W-1:0] a_q;
    logic [WORD_W-1:0] b_q;
    logic [WORD_W-1:0] cipher_q;
    logic [WORD_W-1:0] word_c;
    logic              cipher_tail_unused;

    assign in_ready = (state == ST_SHIFT);
    assign busy     = (state != ST_IDLE);
    assign word_c   = a_q ^ (mode_r ? '0 : b_q) ^ key_r[word_idx*WORD_W +: WORD_W];

    serdes_shift_word #(.WORD_W(WORD_W)) u_shift_a (
        .clk(clk), .rst(rst), .load(1'b0), .load_val('0),
        .shift_en(in_ready), .shift_in(a_bit), .q(a_q)
    );

    serdes_shift_word #(.WORD_W(WORD_W)) u_shift_b (
        .clk(clk), .rst(rst), .load(1'b0), .load_val('0),
        .shift_en(in_ready), .shift_in(b_bit), .q(b_q)
    );

    // MSB goes straight to cipher_out in XOR, so the register holds the remaining bits.
    serdes_shift_word #(.WORD_W(WORD_W)) u_shift_c (
        .clk(clk), .rst(rst), .load(state == ST_XOR), .load_val({word_c[WORD_W-2:0], 1'b0}),
        .shift_en(state == ST_OUT), .shift_in(1'b0), .q(cipher_q)
    );

    assign cipher_tail_unused = ^cipher_q[WORD_W-2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            word_idx     <= '0;
            words_left   <= '0;
            key_r        <= '0;
            mode_r       <= 1'b0;
            cipher_out   <= 1'b0;
            cipher_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        key_r      <= key;
                        mode_r     <= mode;
                        words_left <= burst_len;
                        word_idx   <= '0;
                        bit_cnt    <= CNT_LAST;
                        if (burst_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt == '0) begin
                        state <= ST_XOR;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                ST_XOR: begin
                    cipher_out   <= word_c[WORD_W-1];
                    cipher_valid <= 1'b1;
                    bit_cnt      <= CNT_LAST;
                    state        <= ST_OUT;
                end
                ST_OUT: begin
                    if (bit_cnt != '0) begin
                        cipher_out <= cipher_q[WORD_W-1];
                        bit_cnt    <= bit_cnt - CNT_W'(1);
                    end else begin
                        cipher_out   <= 1'b0;
                        cipher_valid <= 1'b0;
                        word_idx     <= (word_idx == IDX_LAST) ? '0 : word_idx + IDX_W'(1);
                        if (words_left == LEN_W'(1)) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            words_left <= words_left - LEN_W'(1);
                            bit_cnt    <= CNT_LAST;
                            state      <= ST_SHIFT;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_secure_serdes_burst_encryptor.sv
// Self-checking bench: per-cycle timing model plus word-level ciphertext model.
module tb_secure_serdes_burst_encryptor;

    localparam int W      = 8;
    localparam int KW     = 128;
    localparam int LW     = 5;
    localparam int P      = 2 * W + 1;
    localparam int SLICES = KW / W;
    localparam logic [KW-1:0] KEY = 128'hA1B2_C3D4_E5F6_0123_4567_89AB_CDEF_1234;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [LW-1:0] burst_len;
    logic [KW-1:0] key;
    logic          a_bit;
    logic          b_bit;
    logic          in_ready;
    logic          cipher_out;
    logic          cipher_valid;
    logic          done;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] a_words[32];
    logic [W-1:0] b_words[32];
    logic [W-1:0] got_words[32];

    secure_serdes_burst_encryptor #(.WORD_W(W), .KEY_W(KW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .burst_len(burst_len),
        .key(key), .a_bit(a_bit), .b_bit(b_bit), .in_ready(in_ready),
        .cipher_out(cipher_out), .cipher_valid(cipher_valid), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_word(input int w, input bit m, input logic [KW-1:0] k);
        logic [W-1:0] ks;
        ks = k[(w % SLICES)*W +: W];
        return a_words[w] ^ (m ? {W{1'b0}} : b_words[w]) ^ ks;
    endfunction

    task automatic tick_idle(input int ncyc, input string tag);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready got %b want 0", tag, in_ready); end
            checks++; if (cipher_valid !== 1'b0) begin errors++; $display("FAIL %s cipher_valid got %b want 0", tag, cipher_valid); end
            checks++; if (cipher_out !== 1'b0) begin errors++; $display("FAIL %s cipher_out got %b want 0", tag, cipher_out); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done got %b want 0", tag, done); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy got %b want 0", tag, busy); end
        end
    endtask

    // Current cycle is cycle 0: start is raised now. Every cycle up to the done
    // cycle is checked against the timing rules; bits are captured into got_words.
    task automatic run_burst(input int len, input bit m, input logic [KW-1:0] k,
                             input bit hold, input int abort_at);
        int last, w, ph;
        bit e_busy, e_rdy, e_val, e_out, e_done;
        logic [W-1:0] exp_w[32];
        last = (len == 0) ? 1 : len * P + 1;
        for (int i = 0; i < len; i++) begin
            exp_w[i] = model_word(i, m, k);
            got_words[i] = '0;
        end
        start = 1'b1; mode = m; burst_len = LW'(len); key = k;
        for (int n = 1; n <= last; n++) begin
            @(posedge clk); #1;
            w = (n - 1) / P;
            ph = (n - 1) % P;
            e_busy = (len > 0) && (n <= len * P);
            e_rdy  = e_busy && (ph < W);
            e_val  = e_busy && (ph > W);
            e_out  = e_val ? exp_w[w][2*W - ph] : 1'b0;
            e_done = (n == last);
            checks++; if (in_ready !== e_rdy) begin errors++; $display("FAIL in_ready len=%0d cyc=%0d got %b want %b", len, n, in_ready, e_rdy); end
            checks++; if (cipher_valid !== e_val) begin errors++; $display("FAIL cipher_valid len=%0d cyc=%0d got %b want %b", len, n, cipher_valid, e_val); end
            checks++; if (cipher_out !== e_out) begin errors++; $display("FAIL cipher_out len=%0d cyc=%0d got %b want %b", len, n, cipher_out, e_out); end
            checks++; if (done !== e_done) begin errors++; $display("FAIL done len=%0d cyc=%0d got %b want %b", len, n, done, e_done); end
            checks++; if (busy !== e_busy) begin errors++; $display("FAIL busy len=%0d cyc=%0d got %b want %b", len, n, busy, e_busy); end
            if (e_val) got_words[w] = {got_words[w][W-2:0], cipher_out};
            if (n == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort in_ready got %b want 0", in_ready); end
                checks++; if (cipher_valid !== 1'b0) begin errors++; $display("FAIL abort cipher_valid got %b want 0", cipher_valid); end
                checks++; if (cipher_out !== 1'b0) begin errors++; $display("FAIL abort cipher_out got %b want 0", cipher_out); end
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort done got %b want 0", done); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort busy got %b want 0", busy); end
                rst = 1'b0;
                start = 1'b0;
                return;
            end
            if (e_rdy) begin
                a_bit = a_words[w][W-1-ph];
                b_bit = b_words[w][W-1-ph];
            end else begin
                a_bit = 1'($urandom);
                b_bit = 1'($urandom);
            end
            if (n == 1 && !hold) start = 1'b0;
            if (n == 1 && len > 0) begin
                mode = 1'($urandom);
                burst_len = LW'($urandom);
                key = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; burst_len = '0; key = '0; a_bit = 1'b0; b_bit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready got %b want 0", in_ready); end
        checks++; if (cipher_valid !== 1'b0) begin errors++; $display("FAIL reset cipher_valid got %b want 0", cipher_valid); end
        checks++; if (cipher_out !== 1'b0) begin errors++; $display("FAIL reset cipher_out got %b want 0", cipher_out); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
        rst = 1'b0;
        tick_idle(2, "post_reset");
    endtask

    task automatic test_single_word();
        a_words[0] = 8'hF0; b_words[0] = 8'h0F;
        run_burst(1, 1'b0, KEY, 1'b0, 0);
        checks++; if (got_words[0] !== 8'hCB) begin errors++; $display("FAIL single_word got %h want cb", got_words[0]); end
        tick_idle(2, "single_idle");
    endtask

    task automatic test_multi_word();
        logic [W-1:0] exp3[3];
        exp3[0] = 8'h34; exp3[1] = 8'h12; exp3[2] = 8'hEF;
        for (int i = 0; i < 3; i++) begin a_words[i] = '0; b_words[i] = '0; end
        run_burst(3, 1'b0, KEY, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (got_words[i] !== exp3[i]) begin errors++; $display("FAIL multi_word[%0d] got %h want %h", i, got_words[i], exp3[i]); end
        end
        tick_idle(2, "multi_idle");
    endtask

    task automatic test_key_wrap();
        for (int i = 0; i < 17; i++) begin a_words[i] = '0; b_words[i] = '0; end
        run_burst(17, 1'b0, KEY, 1'b0, 0);
        checks++; if (got_words[15] !== 8'hA1) begin errors++; $display("FAIL key_wrap word15 got %h want a1", got_words[15]); end
        checks++; if (got_words[16] !== 8'h34) begin errors++; $display("FAIL key_wrap word16 got %h want 34", got_words[16]); end
        tick_idle(2, "wrap_idle");
    endtask

    task automatic test_mode_a_only();
        a_words[0] = 8'h55; b_words[0] = 8'hFF;
        run_burst(1, 1'b1, KEY, 1'b0, 0);
        checks++; if (got_words[0] !== 8'h61) begin errors++; $display("FAIL mode_a_only got %h want 61", got_words[0]); end
        tick_idle(2, "mode_idle");
    endtask

    task automatic test_reset_mid_burst();
        logic [KW-1:0] k;
        for (int i = 0; i < 3; i++) begin a_words[i] = W'($urandom); b_words[i] = W'($urandom); end
        run_burst(3, 1'b0, KEY, 1'b0, P + W + 4);
        tick_idle(6, "after_abort");
        k = {$urandom, $urandom, $urandom, $urandom};
        a_words[0] = W'($urandom); b_words[0] = W'($urandom);
        run_burst(1, 1'b0, k, 1'b0, 0);
        checks++; if (got_words[0] !== model_word(0, 1'b0, k)) begin errors++; $display("FAIL restart_word got %h want %h", got_words[0], model_word(0, 1'b0, k)); end
        tick_idle(2, "restart_idle");
    endtask

    task automatic test_zero_len();
        run_burst(0, 1'b0, KEY, 1'b0, 0);
        tick_idle(4, "zero_len_idle");
    endtask

    task automatic test_back_to_back();
        logic [KW-1:0] k;
        k = {$urandom, $urandom, $urandom, $urandom};
        a_words[0] = W'($urandom); b_words[0] = W'($urandom);
        run_burst(1, 1'b0, k, 1'b1, 0);
        checks++; if (got_words[0] !== model_word(0, 1'b0, k)) begin errors++; $display("FAIL b2b_first got %h want %h", got_words[0], model_word(0, 1'b0, k)); end
        a_words[0] = W'($urandom); b_words[0] = W'($urandom);
        run_burst(1, 1'b1, k, 1'b0, 0);
        checks++; if (got_words[0] !== model_word(0, 1'b1, k)) begin errors++; $display("FAIL b2b_second got %h want %h", got_words[0], model_word(0, 1'b1, k)); end
        tick_idle(2, "b2b_idle");
    endtask

    task automatic test_random_bursts();
        int len;
        bit m, hold;
        logic [KW-1:0] k;
        for (int b = 0; b < 8; b++) begin
            len = $urandom_range(1, 12);
            m = 1'($urandom);
            k = {$urandom, $urandom, $urandom, $urandom};
            hold = (b < 7) ? 1'($urandom) : 1'b0;
            for (int i = 0; i < len; i++) begin a_words[i] = W'($urandom); b_words[i] = W'($urandom); end
            run_burst(len, m, k, hold, 0);
            for (int i = 0; i < len; i++) begin
                checks++; if (got_words[i] !== model_word(i, m, k)) begin errors++; $display("FAIL random b%0d w%0d got %h want %h", b, i, got_words[i], model_word(i, m, k)); end
            end
            if (!hold) tick_idle($urandom_range(0, 3), "random_gap");
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_multi_word();
        test_key_wrap();
        test_mode_a_only();
        test_reset_mid_burst();
        test_zero_len();
        test_back_to_back();
        test_random_bursts();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
